// File: rtl/mips_state_dumper.sv
// Run controller and state-dump engine for the single-cycle MIPS core.
// Enables the core for RUN_CYCLES clocks, then streams every register-file
// word followed by every data-memory word over a valid/ready interface.
module mips_state_dumper #(
  parameter int unsigned RUN_CYCLES = 10,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              core_run,
  output logic [4:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_is_mem,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W    = (RUN_CYCLES < 1) ? 1 : $clog2(RUN_CYCLES + 1);
  localparam int unsigned IDX_W    = ((ADDR_W > 5) ? ADDR_W : 5) + 1;
  localparam int unsigned RUN_LAST = (RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DUMP_REG,
    S_DUMP_MEM,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                core_run_q, core_run_d;
  logic [4:0]          reg_addr_q, reg_addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic [ADDR_W-1:0]   dump_index_q, dump_index_d;
  logic                dump_is_mem_q, dump_is_mem_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load;

  // Next-state, counters, dump payload and registered output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    dump_valid_d  = dump_valid_q;
    dump_data_d   = dump_data_q;
    dump_index_d  = dump_index_q;
    dump_is_mem_d = dump_is_mem_q;
    load          = !dump_valid_q || dump_ready;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (RUN_CYCLES == 0) ? S_DUMP_REG : S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RUN_LAST)) begin
          state_d = S_DUMP_REG;
          idx_d   = '0;
        end
      end
      S_DUMP_REG: begin
        if (load) begin
          if (idx_q < IDX_W'(NUM_REGS)) begin
            dump_data_d   = reg_rdata;
            dump_index_d  = ADDR_W'(idx_q);
            dump_is_mem_d = 1'b0;
            dump_valid_d  = 1'b1;
            idx_d         = idx_q + IDX_W'(1);
          end else begin
            dump_valid_d = 1'b0;
            state_d      = S_DUMP_MEM;
            idx_d        = '0;
          end
        end
      end
      S_DUMP_MEM: begin
        if (load) begin
          if (idx_q < IDX_W'(MEM_DEPTH)) begin
            dump_data_d   = mem_rdata;
            dump_index_d  = ADDR_W'(idx_q);
            dump_is_mem_d = 1'b1;
            dump_valid_d  = 1'b1;
            idx_d         = idx_q + IDX_W'(1);
          end else begin
            dump_valid_d = 1'b0;
            state_d      = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so they change on the same edge.
    core_run_d = (state_d == S_RUN);
    busy_d     = (state_d == S_RUN) || (state_d == S_DUMP_REG) || (state_d == S_DUMP_MEM);
    done_d     = (state_d == S_DONE);
    reg_addr_d = (state_d == S_DUMP_REG) ? idx_d[4:0] : 5'd0;
    mem_addr_d = (state_d == S_DUMP_MEM) ? idx_d[ADDR_W-1:0] : '0;
  end

  // State and output registers; reset aborts any run or dump in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      core_run_q    <= 1'b0;
      reg_addr_q    <= '0;
      mem_addr_q    <= '0;
      dump_valid_q  <= 1'b0;
      dump_data_q   <= '0;
      dump_index_q  <= '0;
      dump_is_mem_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      core_run_q    <= core_run_d;
      reg_addr_q    <= reg_addr_d;
      mem_addr_q    <= mem_addr_d;
      dump_valid_q  <= dump_valid_d;
      dump_data_q   <= dump_data_d;
      dump_index_q  <= dump_index_d;
      dump_is_mem_q <= dump_is_mem_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign core_run    = core_run_q;
  assign reg_addr    = reg_addr_q;
  assign mem_addr    = mem_addr_q;
  assign dump_valid  = dump_valid_q;
  assign dump_data   = dump_data_q;
  assign dump_index  = dump_index_q;
  assign dump_is_mem = dump_is_mem_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mips_state_dumper.sv
// Directed bench for mips_state_dumper: full runs, backpressure, reset abort,
// start filtering and a zero-length run on a second, small instance.
module tb_mips_state_dumper;

  localparam int RUN_CYC = 10;
  localparam int NREGS   = 32;
  localparam int NMEM    = 256;
  localparam int TOTAL   = NREGS + NMEM;
  localparam int BUDGET  = 3000;

  typedef logic [40:0] word_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        core_run;
  logic [4:0]  reg_addr;
  logic [31:0] reg_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [7:0]  dump_index;
  logic        dump_is_mem;
  logic        busy;
  logic        done;

  logic        start0;
  logic        core_run0;
  logic [4:0]  reg_addr0;
  logic [31:0] reg_rdata0;
  logic [7:0]  mem_addr0;
  logic [31:0] mem_rdata0;
  logic        dump_valid0;
  logic        dump_ready0;
  logic [31:0] dump_data0;
  logic [7:0]  dump_index0;
  logic        dump_is_mem0;
  logic        busy0;
  logic        done0;

  logic [31:0] regs [32];
  logic [31:0] mem  [256];

  int n_asserts;
  int n_fail;

  assign reg_rdata  = regs[reg_addr];
  assign mem_rdata  = mem[mem_addr];
  assign reg_rdata0 = regs[reg_addr0];
  assign mem_rdata0 = mem[mem_addr0];

  mips_state_dumper #(
    .RUN_CYCLES(RUN_CYC), .NUM_REGS(NREGS), .MEM_DEPTH(NMEM), .ADDR_W(8), .DATA_W(32)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .core_run(core_run),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_index(dump_index), .dump_is_mem(dump_is_mem), .busy(busy), .done(done)
  );

  mips_state_dumper #(
    .RUN_CYCLES(0), .NUM_REGS(4), .MEM_DEPTH(4), .ADDR_W(8), .DATA_W(32)
  ) dut0 (
    .clock(clock), .reset(reset), .start(start0), .core_run(core_run0),
    .reg_addr(reg_addr0), .reg_rdata(reg_rdata0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0),
    .dump_valid(dump_valid0), .dump_ready(dump_ready0), .dump_data(dump_data0),
    .dump_index(dump_index0), .dump_is_mem(dump_is_mem0), .busy(busy0), .done(done0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t exp_word(input int k, input int nregs);
    if (k < nregs) return {1'b0, 8'(k), regs[k]};
    return {1'b1, 8'(k - nregs), mem[k - nregs]};
  endfunction

  // One start pulse followed by cycle-by-cycle observation until done or abort.
  task automatic do_run(input bit bp, input bit inj, input int abort_k);
    int    run_hi;
    int    viol;
    int    first_v;
    int    done_c;
    int    k;
    bit    stall;
    bit    aborted;
    word_t held;
    word_t cur;
    logic [3:0] pat;
    run_hi = 0; viol = 0; first_v = -1; done_c = -1; k = 0;
    stall = 1'b0; aborted = 1'b0; held = '0; pat = 4'b1001;
    @(negedge clock);
    start = 1'b1;
    dump_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      cur = {dump_is_mem, dump_index, dump_data};
      if (c == 1) check("run_entry", 64'({busy, core_run, done}), 64'(3'b110));
      if (core_run) begin
        run_hi++;
        if (dump_valid || c > RUN_CYC) viol++;
      end
      if (dump_valid && first_v < 0) first_v = c;
      if (stall) check("stall_hold", 64'({dump_valid, cur}), 64'({1'b1, held}));
      if (done) begin
        done_c = c;
        break;
      end
      if (abort_k >= 0 && dump_valid && k == abort_k) begin
        reset = 1'b0;
        #1;
        check("abort", 64'({dump_valid, busy, done, core_run, dump_index}), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        dump_ready = 1'b1;
        aborted = 1'b1;
        break;
      end
      start = inj && (c == 3 || c == 40);
      dump_ready = bp ? (pat[c % 4] ^ ($urandom_range(0, 7) == 0)) : 1'b1;
      if (dump_valid && dump_ready) begin
        check("word", 64'(cur), 64'(exp_word(k, NREGS)));
        if (k == 5)  check("reg5", 64'({dump_is_mem, dump_data}), 64'({1'b0, 32'h0000_00A5}));
        if (k == 35) check("mem3", 64'({dump_is_mem, dump_data}), 64'({1'b1, 32'hDEAD_BEEF}));
        k++;
      end
      stall = dump_valid && !dump_ready;
      held = cur;
      @(negedge clock);
    end
    start = 1'b0;
    dump_ready = 1'b1;
    if (!aborted) begin
      check("run_cycles", 64'(run_hi), 64'(RUN_CYC));
      check("core_run_window", 64'(viol), 64'(0));
      check("first_valid", 64'(first_v), 64'(RUN_CYC + 2));
      check("transfers", 64'(k), 64'(TOTAL));
      check("done_reached", 64'({done_c > 0, done, busy}), 64'(3'b110));
      if (!bp) check("done_cycle", 64'(done_c), 64'(RUN_CYC + 2 + TOTAL + 1));
    end
  endtask

  initial begin
    int hi0;
    int fv0;
    int k0;
    int dc0;
    n_asserts = 0;
    n_fail = 0;
    clock = 1'b0;
    reset = 1'b0;
    start = 1'b0;
    dump_ready = 1'b1;
    start0 = 1'b0;
    dump_ready0 = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + 32'(i * 3);
    regs[5] = 32'h0000_00A5;
    mem[3]  = 32'hDEAD_BEEF;

    #1;
    check("reset_ctrl", 64'({core_run, dump_valid, busy, done, dump_is_mem}), 64'(0));
    check("reset_data", 64'({dump_data, dump_index, reg_addr, mem_addr}), 64'(0));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_hold", 64'({busy, done, core_run}), 64'(0));

    do_run(1'b0, 1'b0, -1);
    do_run(1'b0, 1'b1, -1);
    do_run(1'b1, 1'b0, -1);
    do_run(1'b0, 1'b0, 10);
    check("idle_after_abort", 64'({busy, done, dump_valid}), 64'(0));
    do_run(1'b0, 1'b0, -1);

    // Zero-length run on the small instance.
    hi0 = 0; fv0 = -1; k0 = 0; dc0 = -1;
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    for (int c = 1; c < 100; c++) begin
      if (core_run0) hi0++;
      if (dump_valid0 && fv0 < 0) fv0 = c;
      if (dump_valid0) begin
        check("word0", 64'({dump_is_mem0, dump_index0, dump_data0}), 64'(exp_word(k0, 4)));
        k0++;
      end
      if (done0) begin
        dc0 = c;
        break;
      end
      @(negedge clock);
    end
    check("zero_core_run", 64'(hi0), 64'(0));
    check("zero_first_valid", 64'(fv0), 64'(2));
    check("zero_transfers", 64'(k0), 64'(8));
    check("zero_done_cycle", 64'(dc0), 64'(11));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_state_dumper.md
Name: mips_state_dumper

Overview:
- Run controller and state-dump engine directly downstream of the single-cycle MIPS core.
- On start, enables the core for a fixed number of clock cycles, then freezes it.
- Reads out every register-file word, then every data-memory word, over a valid/ready stream.
- Replaces end-of-simulation memory dumps with a synthesizable, checkable readout path.

Parameters:
RUN_CYCLES, 10, number of cycles core_run is asserted per run (0 allowed)
NUM_REGS, 32, register-file words dumped (1..32)
MEM_DEPTH, 256, data-memory words dumped (>=1)
ADDR_W, 8, data-memory word-address width (2**ADDR_W >= MEM_DEPTH)
DATA_W, 32, word width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle run request; honoured only in IDLE or DONE
core_run  output  1  core enable; high only while running
reg_addr  output  5  register-file read address
reg_rdata  input  DATA_W  register-file read data, combinational from reg_addr
mem_addr  output  ADDR_W  data-memory word read address
mem_rdata  input  DATA_W  data-memory read data, combinational from mem_addr
dump_valid  output  1  dump word available
dump_ready  input  1  sink accepts word
dump_data  output  DATA_W  dumped word
dump_index  output  ADDR_W  register number or memory word index of dump_data
dump_is_mem  output  1  0 = register word, 1 = memory word
busy  output  1  high in RUN, DUMP_REG, DUMP_MEM
done  output  1  high in DONE

Behaviour:
- Reset (reset==0), asynchronous:
  - state=IDLE.
  - core_run, dump_valid, busy, done = 0.
  - dump_data, dump_index, dump_is_mem, reg_addr, mem_addr = 0.
  - run counter and idx = 0.
  - Reset mid-run or mid-dump aborts immediately; no partial word is held.
- States and transitions:
  - IDLE: start=1 -> RUN with counter=0. If RUN_CYCLES==0, go directly to DUMP_REG.
  - RUN:
    - core_run=1 for exactly RUN_CYCLES consecutive cycles; counter increments each cycle.
    - In the cycle where counter==RUN_CYCLES-1 -> DUMP_REG with idx=0.
    - core_run is registered: it deasserts on the same edge as the state change.
  - DUMP_REG / DUMP_MEM:
    - load = !dump_valid || dump_ready.
    - On load with idx<limit (NUM_REGS or MEM_DEPTH):
      - dump_data<=rdata (registered).
      - dump_index<=idx, dump_is_mem<=(state==DUMP_MEM).
      - dump_valid<=1, idx<=idx+1.
    - On load with idx==limit:
      - dump_valid<=0.
      - DUMP_REG -> DUMP_MEM with idx=0.
      - DUMP_MEM -> DONE.
  - DONE: done=1. start=1 -> RUN (counter cleared), identical to IDLE.
- Address outputs:
  - reg_addr = idx[4:0] in DUMP_REG, else 0.
  - mem_addr = idx[ADDR_W-1:0] in DUMP_MEM, else 0.
- Handshake:
  - While dump_valid=1 and dump_ready=0: dump_data, dump_index, dump_is_mem stay stable and idx does not advance.
  - A word transfers on any edge where valid && ready.
  - With ready held high: one word per cycle, plus one bubble cycle at the REG->MEM boundary and one at DUMP_MEM->DONE.
- Ordering and counts:
  - Order: reg 0..NUM_REGS-1, then mem 0..MEM_DEPTH-1.
  - Exactly NUM_REGS+MEM_DEPTH transfers per run; no duplicates, no skips.
- start outside IDLE/DONE is ignored.
- core_run is 0 in every dump state, so core state is frozen during readout.
- Latency: the first register word is valid 2 cycles after the last core_run cycle.
- Counter width: clog2(RUN_CYCLES+1). idx width: max(5, ADDR_W)+1, so it reaches the limit without wrap.

Test Plan:
- Reset then a 1-cycle start pulse, ready=1 -> core_run high for exactly 10 cycles. Then 32 register words with is_mem=0 and indices 0..31, then 256 memory words with is_mem=1 and indices 0..255. done=1; total transfers = 288.
- Preload reg[5]=0x0000_00A5 and mem[3]=0xDEAD_BEEF -> dump index 5 (is_mem=0) carries 0x000000A5; index 3 (is_mem=1) carries 0xDEADBEEF.
- Backpressure: ready toggles 1,0,0,1 pseudo-randomly -> data and index stable across every stall. Output sequence identical to the ready=1 run.
- RUN_CYCLES=0 -> core_run never asserts. First dump_valid 2 cycles after start.
- Assert reset low at register word 10 -> dump_valid=0 and state=IDLE without waiting for a clock edge. A new start gives a full 288-word dump.
- start pulses during RUN and during dumping are ignored. start in DONE launches a second complete run with the same 10-cycle core_run window.
